// File: rtl/param_pipelined_accumulator_pkg.sv
// Shared definitions for the pipelined accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding used by the top-level controller.
package param_pipelined_accumulator_pkg;

  // 2-bit FSM encoding: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
  typedef enum logic [1:0] {
    PACC_IDLE  = 2'd0,
    PACC_ISSUE = 2'd1,
    PACC_DRAIN = 2'd2,
    PACC_DONE  = 2'd3
  } pacc_state_e;

endpackage

// File: rtl/param_pipelined_accumulator_pipe_stage.sv
// One valid+data register stage of the accumulator's memory-return pipe.
// Latency: 1 cycle per stage when enabled.
// Backpressure: en=0 holds both valid and data (used for whole-block stall).
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   en                load enable; low freezes the stage
//   in_vld, in_dat    upstream valid/data
//   out_vld, out_dat  registered valid/data
module param_pipelined_accumulator_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (en) begin
      vld_d = in_vld;
      dat_d = in_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/param_pipelined_accumulator.sv
// Pipelined accumulator: reads LEN words from an async-read memory starting at
//   base_addr and sums them; optional saturation via macro ACC_SATURATE_EN.
// Latency: word issued in cycle t is visible in sum at t+PIPE_DEPTH+1; 1 word/cycle.
// Backpressure: stall=1 freezes FSM, counters, mem_addr, every pipe stage and sum.
// Ports:
//   clk, reset         rising-edge clock, async active-high reset
//   start              begin a run (taken only in IDLE and not stalled)
//   base_addr, len     first word address / word count, latched at start
//   stall              freeze the block this cycle
//   mem_addr, mem_data word address out, same-cycle read data in
//   sum                accumulator value
//   busy               high in ISSUE and DRAIN
//   done               one-cycle pulse when sum is final (never while stalled)
//   overflow           sticky carry-out flag for the current run
module param_pipelined_accumulator
  import param_pipelined_accumulator_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 30,
  parameter int LEN_W      = 16,
  parameter int PIPE_DEPTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_data,
  output logic [WIDTH-1:0]  sum,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  pacc_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Index 0 is the pipe input; index k is the output of stage k.
  logic [PIPE_DEPTH:0] pipe_vld;
  logic [WIDTH-1:0]    pipe_dat [PIPE_DEPTH+1];

  assign pipe_vld[0] = (state_q == PACC_ISSUE);
  assign pipe_dat[0] = mem_data;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_pipe
    param_pipelined_accumulator_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (~stall),
      .in_vld  (pipe_vld[k]),
      .in_dat  (pipe_dat[k]),
      .out_vld (pipe_vld[k+1]),
      .out_dat (pipe_dat[k+1])
    );
  end

  // One extra bit captures the carry-out of the unsigned add.
  logic [WIDTH:0] add_full;
  assign add_full = {1'b0, sum_q} + {1'b0, pipe_dat[PIPE_DEPTH]};

  // Any word still upstream of the last stage. The last stage's word commits
  // on the coming edge, so DRAIN can finish once everything before it is empty.
  logic upstream_vld;
  always_comb begin
    upstream_vld = 1'b0;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      upstream_vld = upstream_vld | pipe_vld[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;

    if (!stall) begin
      if (pipe_vld[PIPE_DEPTH]) begin
        if (add_full[WIDTH]) begin
          ovf_d = 1'b1;
        end
`ifdef ACC_SATURATE_EN
        // Once clamped, the sum stays at all-ones for the rest of the run.
        if (add_full[WIDTH] || ovf_q) begin
          sum_d = '1;
        end else begin
          sum_d = add_full[WIDTH-1:0];
        end
`else
        sum_d = add_full[WIDTH-1:0];
`endif
      end

      case (state_q)
        PACC_IDLE: begin
          if (start) begin
            addr_d   = base_addr;
            remain_d = len;
            sum_d    = '0;
            ovf_d    = 1'b0;
            state_d  = (len == '0) ? PACC_DONE : PACC_ISSUE;
          end
        end
        PACC_ISSUE: begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = PACC_DRAIN;
          end
        end
        PACC_DRAIN: begin
          if (!upstream_vld) begin
            state_d = PACC_DONE;
          end
        end
        default: begin
          state_d = PACC_IDLE;
        end
      endcase
    end

    busy_d = (state_d == PACC_ISSUE) || (state_d == PACC_DRAIN);
    done_d = (state_d == PACC_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= PACC_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mem_addr = addr_q;
  assign sum      = sum_q;
  assign busy     = busy_q;
  // A stall during DONE holds the state, so the pulse is simply deferred.
  assign done     = done_q & ~stall;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_param_pipelined_accumulator.sv
// Directed bench for param_pipelined_accumulator.
// Instance a: WIDTH=32, ADDR_W=30, PIPE_DEPTH=1. Instance b: WIDTH=8, ADDR_W=8, PIPE_DEPTH=3.
// Cycle n is the period after clock edge n; the start pulse is sampled at edge 0.
module tb_param_pipelined_accumulator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance a
  logic        start_a, stall_a, busy_a, done_a, ovf_a;
  logic [29:0] base_a, mem_addr_a;
  logic [15:0] len_a;
  logic [31:0] mem_data_a, sum_a;
  logic [31:0] mem_a [16];
  assign mem_data_a = mem_a[mem_addr_a[3:0]];

  // Instance b
  logic        start_b, stall_b, busy_b, done_b, ovf_b;
  logic [7:0]  base_b, mem_addr_b, len_b, mem_data_b, sum_b;
  logic [7:0]  mem_b [16];
  assign mem_data_b = mem_b[mem_addr_b[3:0]];

  param_pipelined_accumulator #(
    .WIDTH(32), .ADDR_W(30), .LEN_W(16), .PIPE_DEPTH(1)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a), .len(len_a),
    .stall(stall_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a), .sum(sum_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a)
  );

  param_pipelined_accumulator #(
    .WIDTH(8), .ADDR_W(8), .LEN_W(8), .PIPE_DEPTH(3)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b), .len(len_b),
    .stall(stall_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b), .sum(sum_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick_a(input logic [29:0] b, input logic [15:0] l);
    start_a = 1'b1; base_a = b; len_a = l;
    step();
    start_a = 1'b0;
  endtask

  task automatic kick_b(input logic [7:0] b, input logic [7:0] l);
    start_b = 1'b1; base_b = b; len_b = l;
    step();
    start_b = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 32'(i + 1);
      mem_b[i] = 8'h00;
    end
    mem_b[0] = 8'd5; mem_b[1] = 8'd6; mem_b[2] = 8'd7;
    mem_b[4] = 8'hF0; mem_b[5] = 8'h20;

    reset = 1'b1;
    start_a = 0; stall_a = 0; base_a = '0; len_a = '0;
    start_b = 0; stall_b = 0; base_b = '0; len_b = '0;
    step();
    step();
    chk("rst_sum_a", sum_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_addr_a", mem_addr_a, 0);
    chk("rst_sum_b", sum_b, 0);
    chk("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    step();

    // Test 1: base 0, len 4, data 1..4
    kick_a(30'd0, 16'd4);
    chk("t1_addr_c1", mem_addr_a, 0);
    chk("t1_busy_c1", busy_a, 1);
    step(); chk("t1_addr_c2", mem_addr_a, 1);
    step(); chk("t1_addr_c3", mem_addr_a, 2);
    chk("t1_sum_c3", sum_a, 1);
    step(); chk("t1_addr_c4", mem_addr_a, 3);
    chk("t1_sum_c4", sum_a, 3);
    step(); chk("t1_done_c5", done_a, 0);
    chk("t1_busy_c5", busy_a, 1);
    step(); chk("t1_sum_c6", sum_a, 10);
    chk("t1_done_c6", done_a, 1);
    chk("t1_busy_c6", busy_a, 0);
    step(); chk("t1_done_c7", done_a, 0);
    chk("t1_sum_hold", sum_a, 10);

    // Test 2: len 0 -> immediate done, sum cleared
    kick_a(30'd5, 16'd0);
    chk("t2_done_c1", done_a, 1);
    chk("t2_sum_c1", sum_a, 0);
    chk("t2_busy_c1", busy_a, 0);
    step(); chk("t2_done_c2", done_a, 0);
    chk("t2_busy_c2", busy_a, 0);

    // Stall during DONE defers the pulse
    kick_a(30'd0, 16'd0);
    stall_a = 1'b1;
    #1 chk("stl_done_masked", done_a, 0);
    step();
    chk("stl_done_held", done_a, 0);
    stall_a = 1'b0;
    #1 chk("stl_done_late", done_a, 1);
    step(); chk("stl_done_gone", done_a, 0);

    // Start together with stall in IDLE is not taken
    stall_a = 1'b1; start_a = 1'b1; base_a = 30'd0; len_a = 16'd4;
    step();
    stall_a = 1'b0; start_a = 1'b0;
    chk("ss_busy_c1", busy_a, 0);
    step(); chk("ss_busy_c2", busy_a, 0);

    // Test 5: address wrap; data at low nibble E,F,0,1 -> 15+16+1+2
    kick_a(30'h3FFF_FFFE, 16'd4);
    chk("t5_addr_c1", mem_addr_a, 30'h3FFF_FFFE);
    step(); chk("t5_addr_c2", mem_addr_a, 30'h3FFF_FFFF);
    step(); chk("t5_addr_c3", mem_addr_a, 0);
    step(); chk("t5_addr_c4", mem_addr_a, 1);
    step();
    step(); chk("t5_sum_c6", sum_a, 34);
    chk("t5_done_c6", done_a, 1);
    step();

    // Test 4: WIDTH=8 carry-out, PIPE_DEPTH=3
    kick_b(8'd4, 8'd2);
    chk("t4_ovf_c1", ovf_b, 0);
    step(); step(); step();
    step(); chk("t4_sum_c5", sum_b, 8'hF0);
    chk("t4_ovf_c5", ovf_b, 0);
    step();
`ifdef ACC_SATURATE_EN
    chk("t4_sum_c6", sum_b, 8'hFF);
`else
    chk("t4_sum_c6", sum_b, 8'h10);
`endif
    chk("t4_ovf_c6", ovf_b, 1);
    chk("t4_done_c6", done_b, 1);
    step(); chk("t4_ovf_hold", ovf_b, 1);
    chk("t4_done_c7", done_b, 0);

    // Test 3: PIPE_DEPTH=3, data 5,6,7 -> 18 in cycle 7
    kick_b(8'd0, 8'd3);
    chk("t3_ovf_clr", ovf_b, 0);
    chk("t3_sum_clr", sum_b, 0);
    step(); step(); step(); step();
    step(); chk("t3_done_c6", done_b, 0);
    step(); chk("t3_sum_c7", sum_b, 18);
    chk("t3_done_c7", done_b, 1);
    step();

    // Test 3 with stall in cycles 2-3 -> done in cycle 9
    kick_b(8'd0, 8'd3);
    step();
    stall_b = 1'b1;
    #1 chk("t3s_addr_c2", mem_addr_b, 1);
    chk("t3s_sum_c2", sum_b, 0);
    step(); chk("t3s_addr_c3", mem_addr_b, 1);
    chk("t3s_sum_c3", sum_b, 0);
    step();
    stall_b = 1'b0;
    chk("t3s_addr_c4", mem_addr_b, 1);
    step(); chk("t3s_addr_c5", mem_addr_b, 2);
    step();
    step(); chk("t3s_sum_c7", sum_b, 5);
    chk("t3s_done_c7", done_b, 0);
    step(); chk("t3s_sum_c8", sum_b, 11);
    chk("t3s_done_c8", done_b, 0);
    step(); chk("t3s_sum_c9", sum_b, 18);
    chk("t3s_done_c9", done_b, 1);
    step();

    // Test 6: asynchronous reset mid-ISSUE, then a clean run
    kick_a(30'd0, 16'd8);
    step();
    step(); chk("t6_sum_pre", sum_a, 1);
    chk("t6_busy_pre", busy_a, 1);
    #2 reset = 1'b1;
    #1 chk("t6_sum_rst", sum_a, 0);
    chk("t6_busy_rst", busy_a, 0);
    chk("t6_done_rst", done_a, 0);
    chk("t6_addr_rst", mem_addr_a, 0);
    #1 reset = 1'b0;
    step();
    kick_a(30'd0, 16'd3);
    step();
    start_a = 1'b1; base_a = 30'd9; len_a = 16'd2;
    step();
    start_a = 1'b0;
    chk("t6_addr_c3", mem_addr_a, 2);
    step();
    step(); chk("t6_sum_c5", sum_a, 6);
    chk("t6_done_c5", done_a, 1);
    step(); chk("t6_busy_after", busy_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
